mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator between the processor datapath and the word-wide data memory (ports AM, DM_, EW, DM; 32 words, word-indexed, combinational read, write on clock negedge). It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It converts each request into word-indexed memory accesses, performing read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or an error for misaligned or out-of-range addresses.

## Interface
- MEM_WORDS, 32, number of 32-bit words in data memory; valid word index is 0..MEM_WORDS-1
- clk  in  1  clock; all state changes on posedge; memory writes on negedge
- rst_n  in  1  synchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or reserved size
- AM  out  32  memory word index = {2'b00, addr[31:2]}
- DM_  out  32  memory write data
- EW  out  1  memory write enable
- DM  in  32  memory read data, combinational from AM

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- req_ready = (state == IDLE). Accept on req_valid && req_ready at posedge; latch we, size, signed, addr, wdata.
- Error check at acceptance:
  - size 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:2] >= MEM_WORDS
- On error: IDLE -> RESP with resp_err = 1 and resp_rdata = 0. EW is never asserted and AM is not changed.
- Load: IDLE -> READ -> RESP.
  - In READ: AM = word index; DM is sampled at the next posedge.
  - Lane select is little-endian: byte k = DM[8k+7:8k] with k = addr[1:0]; half = DM[15:0] if addr[1] = 0, else DM[31:16].
  - The selected lane is extended per latched signed.
- Word store: IDLE -> WRITE -> RESP.
  - In WRITE: AM = index, DM_ = wdata, EW = 1.
- Sub-word store: IDLE -> READ -> WRITE -> RESP.
  - READ captures the old word.
  - WRITE drives DM_ = old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]; all other bytes are unchanged.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- AM, DM_ and EW are registered and stable for the whole state cycle, so the negedge write sees settled values.
- EW = 1 only in WRITE.
- In IDLE, AM holds its last value and DM_ holds its last value.

## Timing
- Reset values (rst_n low at posedge):
  - state = IDLE
  - req_ready = 1 after reset
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - AM = 0, DM_ = 0, EW = 0
  - req_valid is ignored while rst_n is low.
- Latency, accept edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput is one request per latency + 1 cycles: req_ready is low from the accept edge until the cycle after RESP.
- Store data is in memory at the negedge inside WRITE, before resp_valid rises.
- Reset in READ or WRITE returns to IDLE with EW = 0 from that edge on. The pending response is dropped.
  - A WRITE cycle cut by reset before its negedge performs no write.
  - A WRITE cycle cut by reset after its negedge has already written.
- A request presented during RESP is not accepted (req_ready = 0). It must be held until IDLE.

## Structure
- Shared package mau_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - a MEM_WORDS default constant matching the data memory depth
- One sub-module, mau_lane (combinational):
  - extract(word, offset, size, signed) -> 32-bit extended value
  - merge(old, wdata, offset, size) -> new word
- Top holds the FSM, request latch, error check and memory-port registers.

## Test plan
- Memory word 5 = 0x00000009. lw addr 0x14 -> AM = 5, resp_valid 2 cycles after accept, resp_rdata = 0x00000009, err = 0, EW never high.
- sb addr 0x15 wdata 0x000000AB -> READ then WRITE with DM_ = 0x0000AB09 and EW high one cycle. A following lb at 0x15 -> 0xFFFFFFAB; lbu at 0x15 -> 0x000000AB.
- sh addr 0x16 wdata 0x1234 onto 0x0000AB09 -> DM_ = 0x1234AB09. lh at 0x16 -> 0x00001234. sw at 0x14 with 0xDEADBEEF -> 2-cycle latency, no READ state.
- lw addr 0x16 (misaligned), lh addr 0x13, size 11, and lw addr 0x80 (index 32) -> each gives resp_err = 1 one cycle after accept, resp_rdata = 0, EW stays 0, memory unchanged.
- Back-to-back: req_valid held high with two loads -> second accepted only when req_ready returns high. resp_valid pulses are exactly one cycle each.
- rst_n low during the READ of a sub-word store -> no EW pulse, no resp_valid, memory word unchanged, req_ready = 1 on the cycle after reset releases.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

  // Depth of the attached data memory in 32-bit words.
  localparam int unsigned MEM_WORDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  // Request is rejected for a reserved size, misalignment or an index past the memory.
  function automatic logic req_error(input logic [31:0] addr, input size_e size,
                                     input int unsigned words);
    logic bad;
    bad = 1'b0;
    if (size == SZ_RSVD) bad = 1'b1;
    if ((size == SZ_HALF) && addr[0]) bad = 1'b1;
    if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the datapath and the memory access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mau_lane.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        signed_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: ext_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: ext_o = word_i;
    endcase
  end

  // Replace the addressed lane(s) of the old word, leaving other bytes untouched.
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (off_i[1]) merged_o[31:16] = wdata_i;
        else          merged_o[15:0]  = wdata_i;
      end
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: request latch, error check, FSM and registered memory port.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_access_unit_if.slave        bus,
  output logic [31:0]             AM,
  output logic [31:0]             DM_,
  output logic                    EW,
  input  logic [31:0]             DM
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  size_e       size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wlo_q, wlo_d;
  logic [31:0] am_q, am_d;
  logic [31:0] dmw_q, dmw_d;
  logic        ew_q, ew_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] lane_ext;
  logic [31:0] lane_merged;
  size_e       req_size;

  assign req_size = size_e'(bus.req_size);

  mau_lane u_lane (
    .word_i   (DM),
    .wdata_i  (wlo_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .ext_o    (lane_ext),
    .merged_o (lane_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, request latch and next memory-port values.
  // Memory-port values are computed one state ahead so AM/DM_/EW are
  // registered and already settled for the whole READ/WRITE cycle.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wlo_d   = wlo_q;
    am_d    = am_q;
    dmw_d   = dmw_q;
    ew_d    = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = req_size;
          sgn_d   = bus.req_signed;
          off_d   = bus.req_addr[1:0];
          wlo_d   = bus.req_wdata[15:0];
          rdata_d = '0;
          if (req_error(bus.req_addr, req_size, MEM_WORDS)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d = 1'b0;
            am_d  = {2'b00, bus.req_addr[31:2]};
            if (bus.req_we && (req_size == SZ_WORD)) begin
              dmw_d   = bus.req_wdata;
              ew_d    = 1'b1;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          dmw_d   = lane_merged;
          ew_d    = 1'b1;
          state_d = S_WRITE;
        end else begin
          rdata_d = lane_ext;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and memory-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      wlo_q   <= '0;
      am_q    <= '0;
      dmw_q   <= '0;
      ew_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wlo_q   <= wlo_d;
      am_q    <= am_d;
      dmw_q   <= dmw_d;
      ew_q    <= ew_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  assign AM             = am_q;
  assign DM_            = dmw_q;
  assign EW             = ew_q;

endmodule
